hdmi_tx_i2c_master: RTL and testbench

HDMI_TX_I2C_MASTER -- requirements
Module: hdmi_tx_i2c_master

---
 rtl/hdmi_i2c_pkg.sv | 28 ++
 rtl/hdmi_i2c_bit_timer.sv | 35 +++
 rtl/hdmi_tx_i2c_master.sv | 221 ++++++++++++++++++++++
 tb/tb_hdmi_tx_i2c_master.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_i2c_pkg.sv
// Shared types for the HDMI transmitter I2C master.
// FSM state enum, register offsets, CMD and STATUS bit indices.
package hdmi_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP
  } i2c_state_t;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CMD    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int CMD_START = 0;
  localparam int CMD_STOP  = 1;
  localparam int CMD_WR    = 2;
  localparam int CMD_RD    = 3;
  localparam int CMD_NACK  = 4;

  localparam int STAT_BUSY = 0;
  localparam int STAT_NACK = 1;
  localparam int STAT_DONE = 2;

endpackage

// File: rtl/hdmi_i2c_bit_timer.sv
// Quarter-bit timer: each quarter lasts div+1 clks, four quarters per bit.
// Ports: clk, reset_n, run, hold, div in; phase[1:0], quarter_end out.
import hdmi_i2c_pkg::*;

module hdmi_i2c_bit_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        hold,
  input  logic [15:0] div,
  output logic [1:0]  phase,
  output logic        quarter_end
);

  logic [15:0] cnt;

  // A held quarter neither counts nor ends.
  assign quarter_end = run & ~hold & (cnt == div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= '0;
    end else if (!run) begin
      cnt   <= '0;
      phase <= '0;
    end else if (quarter_end) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else if (!hold) begin
      cnt   <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/hdmi_tx_i2c_master.sv
// Avalon-MM I2C master for HDMI transmitter configuration.
// Ports: clk, reset_n, address/chipselect/write_n/writedata,
// readdata, scl_oe/sda_oe (open-drain pulls), scl_in/sda_in.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching.
import hdmi_i2c_pkg::*;

module hdmi_tx_i2c_master #(
  parameter logic [15:0] DIV_RESET = 16'd124
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        scl_in,
  input  logic        sda_in
);

  i2c_state_t state, state_d;

  logic [7:0]  txdata;
  logic [7:0]  rxdata;
  logic [7:0]  shreg;
  logic [15:0] div;
  logic [2:0]  bitcnt;
  logic        rx_nack;
  logic        done;
  logic        held;
  logic        c_stop, c_wr, c_rd, c_nack;

  logic        busy;
  logic        wr_en;
  logic        cmd_acc;
  logic        cmd_wr, cmd_rd;
  logic        set_done;
  logic        enter_idle;
  logic [1:0]  phase;
  logic        quarter_end;
  logic        bit_end;
  logic        sample;
  logic        hold;
  logic        drive_low;
  logic [31:0] rd_next;
  logic        unused_wdata;

  assign busy    = (state != ST_IDLE);
  assign wr_en   = chipselect & ~write_n;
  assign cmd_acc = wr_en & (address == REG_CMD) & ~busy;
  // WR wins when both WR and RD are requested.
  assign cmd_wr  = writedata[CMD_WR];
  assign cmd_rd  = writedata[CMD_RD] & ~writedata[CMD_WR];

  assign bit_end = quarter_end & (phase == 2'd3);
  assign sample  = quarter_end & (phase == 2'd2);

  assign enter_idle = busy & (state_d == ST_IDLE);
  assign set_done   = enter_idle | (cmd_acc & (state_d == ST_IDLE));

  assign unused_wdata = ^writedata[31:16];

`ifdef I2C_CLK_STRETCH_EN
  // SCL released by us but still low: the slave is stretching.
  assign hold = ~scl_oe & ~scl_in;
`else
  logic unused_scl;
  assign hold       = 1'b0;
  assign unused_scl = scl_in;
`endif

  hdmi_i2c_bit_timer u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (busy),
    .hold        (hold),
    .div         (div),
    .phase       (phase),
    .quarter_end (quarter_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: begin
        if (cmd_acc) begin
          if (writedata[CMD_START])       state_d = ST_START;
          else if (cmd_wr | cmd_rd)       state_d = ST_BIT;
          else if (writedata[CMD_STOP])   state_d = ST_STOP;
        end
      end
      ST_START: begin
        if (bit_end) begin
          if (c_wr | c_rd) state_d = ST_BIT;
          else if (c_stop) state_d = ST_STOP;
          else             state_d = ST_IDLE;
        end
      end
      ST_BIT: begin
        if (bit_end && bitcnt == 3'd7) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (bit_end) state_d = c_stop ? ST_STOP : ST_IDLE;
      end
      ST_STOP: begin
        if (bit_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // SDA level wanted for the current data/ack slot.
  assign drive_low = (state == ST_BIT) ? (c_wr & ~shreg[7])
                                       : (c_rd & ~c_nack);

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    unique case (state)
      ST_IDLE: scl_oe = held;
      ST_START: begin
        unique case (phase)
          2'd0: scl_oe = held;
          2'd1: ;
          2'd2: sda_oe = 1'b1;
          2'd3: begin
            scl_oe = 1'b1;
            sda_oe = 1'b1;
          end
          default: ;
        endcase
      end
      ST_BIT, ST_ACK: begin
        scl_oe = (phase == 2'd0) | (phase == 2'd3);
        sda_oe = drive_low;
      end
      ST_STOP: begin
        unique case (phase)
          2'd0: begin
            scl_oe = 1'b1;
            sda_oe = 1'b1;
          end
          2'd1: sda_oe = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txdata  <= '0;
      div     <= DIV_RESET;
      c_stop  <= 1'b0;
      c_wr    <= 1'b0;
      c_rd    <= 1'b0;
      c_nack  <= 1'b0;
      done    <= 1'b0;
      held    <= 1'b0;
    end else begin
      if (wr_en && address == REG_DATA) txdata <= writedata[7:0];
      if (wr_en && address == REG_DIV && !busy) div <= writedata[15:0];
      if (cmd_acc) begin
        c_stop <= writedata[CMD_STOP];
        c_wr   <= cmd_wr;
        c_rd   <= cmd_rd;
        c_nack <= writedata[CMD_NACK];
      end
      if (set_done) done <= 1'b1;
      else if (wr_en && address == REG_STATUS) done <= 1'b0;
      // SCL stays pulled in idle unless the transfer ended in STOP.
      if (enter_idle) held <= (state != ST_STOP);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '0;
      bitcnt  <= '0;
      rxdata  <= '0;
      rx_nack <= 1'b0;
    end else begin
      if (state != ST_BIT && state_d == ST_BIT) begin
        shreg  <= txdata;
        bitcnt <= '0;
      end else if (state == ST_BIT && bit_end) begin
        shreg  <= {shreg[6:0], 1'b0};
        bitcnt <= bitcnt + 3'd1;
      end
      if (state == ST_BIT && c_rd && sample)
        rxdata <= {rxdata[6:0], sda_in};
      if (state == ST_ACK && c_wr && sample)
        rx_nack <= sda_in;
    end
  end

  always_comb begin
    rd_next = '0;
    unique case (address)
      REG_DATA:   rd_next = {24'd0, rxdata};
      REG_CMD:    rd_next = '0;
      REG_STATUS: rd_next = {29'd0, done, rx_nack, busy};
      REG_DIV:    rd_next = {16'd0, div};
      default:    rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

endmodule

// File: tb/tb_hdmi_tx_i2c_master.sv
// Self-checking bench for hdmi_tx_i2c_master.
// Register vectors plus a bus-event scoreboard with a simple slave.
module tb_hdmi_tx_i2c_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        scl_oe, sda_oe;
  logic        scl_in, sda_in;
  logic        slv_scl_low = 1'b0;
  logic        slv_sda_low;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Slave model: 0 passive, 1 ACK a write, 2 transmit slv_byte.
  int         slv_mode = 0;
  int         slv_cnt = 0;
  logic [7:0] slv_byte = '0;
  logic [7:0] slv_sh;

  // Bus events: 0/1 = SCL rise with SDA level, 2 = START, 3 = STOP.
  int   exp_q[$];
  int   pull_q[$];
  bit   mon_en = 1'b0;
  logic p_scl = 1'b1, p_sda = 1'b1, p_oe = 1'b0;

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[7];

  assign scl_in = ~scl_oe & ~slv_scl_low;
  assign sda_in = ~sda_oe & ~slv_sda_low;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hdmi_tx_i2c_master #(.DIV_RESET(16'd124)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .scl_in     (scl_in),
    .sda_in     (sda_in)
  );

  always_comb begin
    slv_sh = slv_byte << slv_cnt[2:0];
    slv_sda_low = 1'b0;
    if (slv_mode == 1 && slv_cnt == 8) slv_sda_low = 1'b1;
    else if (slv_mode == 2 && slv_cnt >= 0 && slv_cnt < 8)
      slv_sda_low = ~slv_sh[7];
  end

  always @(negedge clk) begin
    int ev;
    int e;
    ev = -1;
    if (mon_en) begin
      if (!p_scl && scl_in) ev = sda_in ? 1 : 0;
      else if (p_scl && scl_in && p_sda && !sda_in) ev = 2;
      else if (p_scl && scl_in && !p_sda && sda_in) ev = 3;
    end
    if (ev >= 0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bus_event got %0d exp none", ev);
      end else begin
        e = exp_q.pop_front();
        if (e != ev) begin
          errors++;
          $display("FAIL bus_event got %0d exp %0d", ev, e);
        end
      end
    end
    if (ev == 2) slv_cnt = -1;
    else if (p_scl && !scl_in) slv_cnt++;
    if (!p_oe && scl_oe) pull_q.push_back(cyc);
    p_scl = scl_in;
    p_sda = sda_in;
    p_oe  = scl_oe;
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp,
                        input string name);
    address = a;
    @(posedge clk); #1;
    chk(name, readdata, exp);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    address = 2'd2;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      if (n == 0) chk({name, "_busy"}, {31'd0, readdata[0]}, 32'd1);
      if (!readdata[0]) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_idle"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i] ? 1 : 0);
  endtask

  task automatic chk_period(input string name, input int i, input int exp);
    if (pull_q.size() > i)
      chk(name, pull_q[i] - pull_q[i-1], exp);
    else
      chk({name, "_missing"}, pull_q.size(), i + 1);
  endtask

  initial begin
    int k;
    logic p;
    vt[0] = '{1'b0, 2'd3, 32'h0, 32'd124};
    vt[1] = '{1'b0, 2'd2, 32'h0, 32'd0};
    vt[2] = '{1'b0, 2'd0, 32'h0, 32'd0};
    vt[3] = '{1'b1, 2'd3, 32'hDEAD_0010, 32'h10};
    vt[4] = '{1'b1, 2'd3, 32'd4, 32'd4};
    vt[5] = '{1'b1, 2'd0, 32'hFFFF_FFA0, 32'd0};
    vt[6] = '{1'b0, 2'd1, 32'h0, 32'd0};

    repeat (3) @(negedge clk);
    chk("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (vt[i].wr) bus_wr(vt[i].addr, vt[i].wdata);
      rd_chk(vt[i].addr, vt[i].exp, $sformatf("vec%0d", i));
    end

    bus_wr(2'd1, 32'd0);
    rd_chk(2'd2, 32'd4, "empty_cmd_done");
    bus_wr(2'd2, 32'd0);
    rd_chk(2'd2, 32'd0, "done_clear");

    slv_mode = 1;
    pull_q.delete();
    exp_q.push_back(2);
    push_byte(8'hA0);
    exp_q.push_back(0);
    bus_wr(2'd1, 32'h05);
    wait_idle("wr_a0");
    chk("wr_a0_left", exp_q.size(), 0);
    rd_chk(2'd2, 32'd4, "wr_a0_status");
    chk("wr_a0_scl_held", {31'd0, scl_oe}, 32'd1);
    chk("wr_a0_sda", {31'd0, sda_oe}, 32'd0);
    for (int i = 1; i <= 9; i++)
      chk_period($sformatf("wr_a0_bit%0d_len", i), i, 20);

    slv_mode = 2;
    slv_byte = 8'h5C;
    slv_cnt  = 0;
    push_byte(8'h5C);
    exp_q.push_back(1);
    exp_q.push_back(0);
    exp_q.push_back(3);
    bus_wr(2'd1, 32'h1A);
    wait_idle("rd_5c");
    chk("rd_5c_left", exp_q.size(), 0);
    rd_chk(2'd0, 32'h5C, "rd_5c_rxdata");
    chk("rd_5c_scl", {31'd0, scl_oe}, 32'd0);
    chk("rd_5c_sda", {31'd0, sda_oe}, 32'd0);
    rd_chk(2'd2, 32'd4, "rd_5c_status");

    slv_mode = 0;
    bus_wr(2'd0, 32'h55);
    exp_q.push_back(2);
    push_byte(8'h55);
    exp_q.push_back(1);
    exp_q.push_back(0);
    exp_q.push_back(3);
    bus_wr(2'd1, 32'h07);
    wait_idle("nack");
    chk("nack_left", exp_q.size(), 0);
    rd_chk(2'd2, 32'd6, "nack_status");

    slv_mode = 1;
    bus_wr(2'd0, 32'h3C);
    exp_q.push_back(2);
    push_byte(8'h3C);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(3);
    bus_wr(2'd1, 32'h07);
    repeat (60) @(posedge clk);
    bus_wr(2'd1, 32'h0A);
    bus_wr(2'd3, 32'd0);
    wait_idle("busy_ign");
    chk("busy_ign_left", exp_q.size(), 0);
    rd_chk(2'd3, 32'd4, "busy_ign_div");
    rd_chk(2'd2, 32'd4, "busy_ign_status");

    mon_en   = 1'b0;
    slv_mode = 0;
    bus_wr(2'd0, 32'hFF);
    pull_q.delete();
    bus_wr(2'd1, 32'h07);
    k = 0;
    p = scl_oe;
    for (int n = 0; n < 2000 && k < 3; n++) begin
      @(negedge clk);
      if (p && !scl_oe) k++;
      p = scl_oe;
    end
    chk("stretch_found", k, 3);
    slv_scl_low = 1'b1;
    repeat (50) @(negedge clk);
    slv_scl_low = 1'b0;
    wait_idle("stretch");
    chk_period("stretch_prev_len", 2, 20);
`ifdef I2C_CLK_STRETCH_EN
    chk_period("stretch_len", 3, 70);
`else
    chk_period("stretch_len", 3, 20);
`endif

    bus_wr(2'd0, 32'h00);
    pull_q.delete();
    bus_wr(2'd1, 32'h05);
    for (int n = 0; n < 2000 && pull_q.size() < 6; n++) @(negedge clk);
    chk("rst_mid_pulls", pull_q.size(), 6);
    chk("rst_mid_scl_pre", {31'd0, scl_oe}, 32'd1);
    chk("rst_mid_sda_pre", {31'd0, sda_oe}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_scl", {31'd0, scl_oe}, 32'd0);
    chk("rst_mid_sda", {31'd0, sda_oe}, 32'd0);
    chk("rst_mid_readdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk(2'd3, 32'd124, "rst_mid_div");
    rd_chk(2'd2, 32'd0, "rst_mid_status");
    chk("rst_mid_idle_scl", {31'd0, scl_oe}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
